// File: rtl/arithmetic_left_shift_serial.sv
// Serial arithmetic left shifter: signed multiply by 2^S, one bit per clock.
// Optional saturation on overflow: define ARITH_LEFT_SHIFT_SATURATE_EN.
module arithmetic_left_shift_serial #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_shift,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data,
  output logic          down_overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [SW-1:0] ONE  = SW'(1);
  localparam logic [SW-1:0] ZERO = '0;

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_data;
  logic [SW-1:0] r_cnt;
  logic          r_sign;
  logic          r_ovf;
  logic          w_accept;
  logic          w_last;

  assign up_ready   = (r_state == S_IDLE) ||
                      ((r_state == S_DONE) && down_ready);
  assign down_valid = (r_state == S_DONE);
  assign w_accept   = up_valid && up_ready;
  assign w_last     = (r_cnt == ONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a zero shift goes straight to DONE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (up_shift == ZERO) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (down_ready) begin
          if (up_valid) begin
            w_next = (up_shift == ZERO) ? S_DONE : S_SHIFT;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand load on accept, then one shift per SHIFT cycle.
  // Overflow latches when a bit entering the MSB differs from the sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_sign <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_data <= up_data;
      r_cnt  <= up_shift;
      r_sign <= up_data[N-1];
      r_ovf  <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_data <= {r_data[N-2:0], 1'b0};
      r_ovf  <= r_ovf | (r_data[N-2] != r_sign);
      r_cnt  <= r_cnt - ONE;
    end
  end

  assign down_overflow = r_ovf;

`ifdef ARITH_LEFT_SHIFT_SATURATE_EN
  localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};

  // Clamp to the extreme of the original sign when overflowed.
  always_comb begin
    down_data = r_data;
    if (r_ovf) begin
      down_data = r_sign ? SAT_NEG : SAT_POS;
    end
  end
`else
  // Wrap-around truncation.
  always_comb begin
    down_data = r_data;
  end
`endif

endmodule

// File: tb/tb_arithmetic_left_shift_serial.sv
// Directed-vector bench for arithmetic_left_shift_serial (N=8).
// Expected values are hand-computed; saturation follows the build macro.
module tb_arithmetic_left_shift_serial;

`ifdef ARITH_LEFT_SHIFT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       up_valid;
  logic       up_ready;
  logic [7:0] up_data;
  logic [2:0] up_shift;
  logic       down_valid;
  logic       down_ready;
  logic [7:0] down_data;
  logic       down_overflow;

  int n_chk;
  int n_pass;

  arithmetic_left_shift_serial #(.N(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .up_valid     (up_valid),
    .up_ready     (up_ready),
    .up_data      (up_data),
    .up_shift     (up_shift),
    .down_valid   (down_valid),
    .down_ready   (down_ready),
    .down_data    (down_data),
    .down_overflow(down_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic [7:0] wrap;
    logic       ovf;
  } vec_t;

  vec_t v[11];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_data(input logic [7:0] d,
                                          input logic [7:0] wrap,
                                          input logic       ovf);
    if (SAT && ovf) begin
      return d[7] ? 8'h80 : 8'h7F;
    end
    return wrap;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request with down_ready high; check latency and result.
  task automatic run(input logic [7:0] d, input logic [2:0] s,
                     input logic [7:0] wrap, input logic ovf,
                     input string tag);
    int lat;
    down_ready = 1'b1;
    up_valid   = 1'b1;
    up_data    = d;
    up_shift   = s;
    chk({tag, "_up_ready"}, 32'(up_ready), 32'd1);
    tick();
    up_valid = 1'b0;
    lat = 0;
    while (!down_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(s));
    chk({tag, "_data"}, 32'(down_data), 32'(exp_data(d, wrap, ovf)));
    chk({tag, "_ovf"}, 32'(down_overflow), 32'(ovf));
    tick();
    chk({tag, "_release"}, 32'(down_valid), 32'd0);
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    up_valid   = 1'b0;
    up_data    = '0;
    up_shift   = '0;
    down_ready = 1'b1;

    v[0]  = '{8'hFD, 3'd2, 8'hF4, 1'b0};
    v[1]  = '{8'h20, 3'd2, 8'h80, 1'b1};
    v[2]  = '{8'hC0, 3'd1, 8'h80, 1'b0};
    v[3]  = '{8'hC0, 3'd2, 8'h00, 1'b1};
    v[4]  = '{8'h5A, 3'd0, 8'h5A, 1'b0};
    v[5]  = '{8'h01, 3'd7, 8'h80, 1'b1};
    v[6]  = '{8'hFF, 3'd7, 8'h80, 1'b0};
    v[7]  = '{8'h03, 3'd5, 8'h60, 1'b0};
    v[8]  = '{8'h03, 3'd6, 8'hC0, 1'b1};
    v[9]  = '{8'h80, 3'd0, 8'h80, 1'b0};
    v[10] = '{8'h7F, 3'd1, 8'hFE, 1'b1};

    #12;
    chk("rst_up_ready", 32'(up_ready), 32'd1);
    chk("rst_down_valid", 32'(down_valid), 32'd0);
    chk("rst_down_data", 32'(down_data), 32'd0);
    chk("rst_ovf", 32'(down_overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      run(v[i].d, v[i].s, v[i].wrap, v[i].ovf, $sformatf("vec%0d", i));
    end

    // Stall in DONE, then back-to-back accept on release.
    down_ready = 1'b0;
    up_valid   = 1'b1;
    up_data    = 8'h5A;
    up_shift   = 3'd0;
    tick();
    up_valid = 1'b0;
    chk("hold_first_valid", 32'(down_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("hold_cyc%0d", k),
          {29'd0, down_valid, up_ready, down_overflow},
          {29'd0, 1'b1, 1'b0, 1'b0});
      chk($sformatf("hold_data%0d", k), 32'(down_data), 32'h5A);
    end
    down_ready = 1'b1;
    up_valid   = 1'b1;
    up_data    = 8'hFD;
    up_shift   = 3'd2;
    #1;
    chk("b2b_up_ready", 32'(up_ready), 32'd1);
    tick();
    up_valid = 1'b0;
    chk("b2b_in_shift", 32'(down_valid), 32'd0);
    tick();
    chk("b2b_still_shift", 32'(down_valid), 32'd0);
    tick();
    chk("b2b_valid", 32'(down_valid), 32'd1);
    chk("b2b_data", 32'(down_data), 32'hF4);
    chk("b2b_ovf", 32'(down_overflow), 32'd0);
    tick();

    // Reset mid-SHIFT discards the operation.
    up_valid = 1'b1;
    up_data  = 8'h01;
    up_shift = 3'd7;
    tick();
    up_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_down_valid", 32'(down_valid), 32'd0);
    chk("midrst_up_ready", 32'(up_ready), 32'd1);
    chk("midrst_data", 32'(down_data), 32'd0);
    #10;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("no_stale%0d", k), 32'(down_valid), 32'd0);
    end
    run(8'hFD, 3'd2, 8'hF4, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
